// File: rtl/fetch_unit_if.sv
// Fetch bus bundle: instruction-memory request/response plus the decode-side instruction stream.
// Latency: none, wiring only.
// Backpressure: imem_req_ready stalls requests; instr_ready stalls the decode stream.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_pcplus4,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_pcplus4,
    output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32 fetch stage: PC, credit-limited imem requests, {pc,instr} FIFO; FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect halt.
// Latency: response in cycle N is visible to decode in N+1 (2 cycles fetch-to-decode with 1-cycle memory).
// Backpressure: requests issue only while outstanding + count < DEPTH; instr_ready low fills the FIFO and stops requests.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          fetch_misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  typedef enum logic {FETCH, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          misaligned_q, misaligned_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic [CW:0]   credit_sum;
  logic          req_valid, accept, instr_valid_w, push, pop, misalign_hit;
  logic [31:0]   target;
  entry_t        head;

  always_comb begin
    credit_sum    = {1'b0, outstanding_q} + {1'b0, count_q};
    // Credits use registered occupancy only: a same-cycle pop never frees a slot.
    req_valid     = !reset && (state_q == FETCH) && !redirect && (credit_sum < DEPTH_W);
    accept        = req_valid && bus.imem_req_ready;
    instr_valid_w = !reset && (count_q != '0);
    pop           = instr_valid_w && bus.instr_ready;
    push          = bus.imem_resp_valid && (drop_cnt_q == '0) && !redirect && (state_q == FETCH);
    target        = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_hit  = redirect && (redirect_pc[1:0] != 2'b00);
`else
    misalign_hit  = 1'b0;
`endif
    head          = mem_q[rd_ptr_q];
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    misaligned_d  = misaligned_q;
    mem_d         = mem_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(bus.imem_resp_valid);

    if (redirect) begin
      // Whatever is still in flight after this cycle belongs to the old stream.
      fetch_pc_d = target;
      resp_pc_d  = target;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = outstanding_q - CW'(bus.imem_resp_valid);
      if (misalign_hit) begin
        state_d      = HALT;
        misaligned_d = 1'b1;
      end
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (bus.imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: resp_pc_q, instr: bus.imem_resp_data};
        wr_ptr_d        = wr_ptr_q + 1'b1;
        resp_pc_d       = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      misaligned_q  <= misaligned_d;
    end
    mem_q <= mem_d;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = instr_valid_w;
  assign bus.instr          = head.instr;
  assign bus.instr_pc       = head.pc;
  assign bus.instr_pcplus4  = head.pc + 32'd4;
  assign fetch_misaligned   = misaligned_q && !reset;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32 core, directly upstream of the main/ALU decoders. Holds the PC, issues in-order word requests to instruction memory under a valid/ready handshake, and buffers returned words with their PC in a small FIFO. It presents `instr` (whose `[6:0]` drives the decoder `op`), `instr_pc` and `instr_pcplus4` to decode. On a taken branch/jal redirect it flushes the buffer and discards stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset.
- `DEPTH`, 4, FIFO entries; power of two, >= 2.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_resp_valid` in 1: response word valid. In order, earliest one cycle after acceptance, no backpressure.
- `imem_resp_data` in 32: instruction word.
- `redirect` in 1: taken branch/jump from execute (PCSrc).
- `redirect_pc` in 32: new PC (PCTarget).
- `instr_valid` out 1: FIFO head valid.
- `instr_ready` in 1: decode consumes the head.
- `instr` out 32: head instruction.
- `instr_pc` out 32: head PC.
- `instr_pcplus4` out 32: `instr_pc + 4`, modulo 2^32.
- `fetch_misaligned` out 1: sticky misaligned-redirect flag. Constant 0 unless `FETCH_MISALIGN_TRAP_EN` is defined.

## Operation
- Registers:
  - `fetch_pc`: next request address.
  - `resp_pc`: PC of the next expected response.
  - `outstanding`: accepted requests without a response, 0..DEPTH.
  - `drop_cnt`: in-flight responses to discard, <= `outstanding`.
  - FIFO of {pc, instr}, with `count`.
- States:
  - FETCH: normal operation.
  - HALT: entered only via the misaligned trap. Leaves only on reset.
- Request issue:
  - `imem_req_valid = (state==FETCH) && !redirect && (outstanding + count < DEPTH)`, using registered values only. A pop in the same cycle does not free a credit.
  - `imem_req_addr = fetch_pc`.
  - On accept, `fetch_pc += 4` and `outstanding++`.
  - Address is stable while valid and not ready, except across a redirect. The request is withdrawn in the redirect cycle.
- Response:
  - Each `imem_resp_valid` decrements `outstanding`.
  - If `drop_cnt > 0`: decrement `drop_cnt` and discard the word.
  - Otherwise: push {`resp_pc`, data} and increment `resp_pc` by 4.
  - Overflow is impossible by the credit rule. The bench asserts it never occurs.
- Pop: `instr_valid && instr_ready` removes the head.
- Redirect (highest priority):
  - Next cycle: `count = 0`, `fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}`.
  - `drop_cnt` = in-flight responses after this cycle: `outstanding` minus any response arriving this cycle.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is harmless; the consumed entry is already gone.
- Arithmetic: all PC adds are 32-bit and wrap from 32'hFFFF_FFFC to 0.

## Timing
- During reset and the cycle it is sampled:
  - Outputs: `imem_req_valid=0`, `instr_valid=0`, `fetch_misaligned=0`.
  - State: `fetch_pc = resp_pc = RESET_PC`, `count = outstanding = drop_cnt = 0`, state FETCH.
  - Reset mid-operation abandons in-flight responses. The memory is reset with the core, so none return.
- First request is in the first cycle after reset deasserts.
- Latency:
  - Response in cycle N gives `instr_valid` in N+1. No bypass.
  - Minimum fetch-to-decode latency is 2 cycles with 1-cycle memory.
  - Throughput is 1 instr/cycle at DEPTH=4 with 1-cycle memory and `instr_ready=1`.
- Outputs `instr*` come from FIFO registers only.
- Redirect in cycle R: first new-stream request in R+1; `instr_valid=0` in R+1.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `fetch_misaligned=1` in the next cycle.
  - Enters HALT: FIFO flushed, no further requests, in-flight responses still drained and discarded.
  - `fetch_misaligned` stays 1 until reset.
- Not defined:
  - `redirect_pc[1:0]` is silently cleared.
  - `fetch_misaligned` is tied 0 and HALT is unreachable.

## Test plan
- Reset release, 1-cycle memory returning addr^32'hA5A5_0000, `instr_ready=1` -> requests 0x0, 0x4, 0x8…; first `instr_valid` 2 cycles after the first accept with `instr_pc=0`, `instr_pcplus4=4`; then one instruction per cycle in order.
- `instr_ready=0` for 10 cycles -> `count` saturates at 4, `imem_req_valid=0`, no entry lost. Releasing ready drains PCs 0x0..0xC in order.
- Redirect to 0x100 with 2 requests outstanding and a response arriving the same cycle -> all 3 old words dropped; next `instr_pc=0x100`; no stale PC ever appears.
- `imem_req_ready` low for 5 cycles, then high -> address held constant, each address accepted exactly once.
- `RESET_PC=32'hFFFF_FFF8` -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; `instr_pcplus4` wraps to 0.
- With the macro defined, redirect to 0x102 -> `fetch_misaligned=1` the next cycle, no further requests, `instr_valid=0` until reset. Without the macro -> fetch from 0x100.
